mux_4_to_1: RTL and testbench
=============================

# mux_4_to_1

Registered 4-input, WIDTH-bit multiplexer selecting one of four data words with a 2-bit select split into `s1` (MSB) and `s0` (LSB). Each cycle with `en` high captures the selected word into the output register and raises a one-cycle valid strobe. The block is a leaf datapath element for steering one of four sources onto a shared bus with a clean, registered, glitch-free output.

## Interface
Parameters:
- WIDTH, 1, bit width of each data input and of `y`

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  capture enable; sample inputs on this edge
- i0  input  WIDTH  data input, selected when {s1,s0}=00
- i1  input  WIDTH  data input, selected when {s1,s0}=01
- i2  input  WIDTH  data input, selected when {s1,s0}=10
- i3  input  WIDTH  data input, selected when {s1,s0}=11
- s0  input  1  select LSB
- s1  input  1  select MSB
- y  output  WIDTH  registered selected data
- y_valid  output  1  high for one cycle after each enabled capture
- sel_q  output  2  registered {s1,s0} used for the current `y`

## Operation
- Select decode: {s1,s0} = 00→i0, 01→i1, 10→i2, 11→i3; full decode, no priority, no default-hold path.
- On rising `clk` with `en`=1: `y` ← selected input, `sel_q` ← {s1,s0}, `y_valid` ← 1.
- On rising `clk` with `en`=0: `y` and `sel_q` hold; `y_valid` ← 0.
- Data inputs are passed unmodified; no arithmetic, no width conversion.
- Inputs and select changing while `en`=0 have no effect on any output.
- Back-to-back `en` cycles: every cycle captures independently; `y_valid` stays high continuously.
- Output is purely registered; no combinational path from any input to `y`, `y_valid`, or `sel_q`.

## Timing
- Latency: 1 cycle, from the enabled sampling edge to `y` update; throughput 1 word/cycle.
- Reset values: `y`=0 (all bits), `y_valid`=0, `sel_q`=00; parity output (if compiled) =0.
- `rst` asserted: all outputs go to reset values immediately, independent of `clk`.
- `rst` deasserted: the first capture occurs on the first rising edge with `rst`=0 and `en`=1.
- `rst` asserted mid-stream: it aborts any pending valid strobe, and there is no recovery of the prior value.
- `rst` and `en` high on the same edge: reset wins.

## Configuration
- Macro MUX_4_TO_1_PARITY_EN.
- Defined: adds output `y_par` (1 bit), registered with `y`, equal to the XOR reduction of the selected WIDTH-bit word. It updates only on enabled captures, holds otherwise, and resets to 0.
- Undefined: `y_par` port and logic are absent; all other behaviour is identical.

## Test plan
- Reset: hold `rst`=1 with random inputs toggling → `y`=0, `y_valid`=0, `sel_q`=00 throughout; release → no change until first `en`.
- Select sweep (WIDTH=1): i0=0, i1=1, i2=0, i3=1, `en`=1, {s1,s0}=00,01,10,11 for 10 time units each → `y`=0,1,0,1 one cycle after each, `sel_q` tracks, `y_valid` continuously 1.
- Enable gating: capture with {s1,s0}=01 (`y`=1), then `en`=0 and change to 10 with i2=0 → `y` stays 1, `y_valid`=0, `sel_q`=01.
- Wide data (WIDTH=8): i0=8'hA5, i1=8'h3C, i2=8'hFF, i3=8'h00, cycle through the selects → `y` = A5, 3C, FF, 00; with MUX_4_TO_1_PARITY_EN, `y_par` = 0, 0, 0, 0; with i1=8'h01, `y_par`=1.
- Async reset mid-stream: assert `rst` between clock edges while `y`=8'hFF → `y`=0 and `y_valid`=0 before the next edge.
- Reset/enable collision: `rst`=1 and `en`=1 on the same edge → outputs remain at reset values.

Source files
------------

// File: rtl/mux_4_to_1.sv
// mux_4_to_1: registered 4:1 WIDTH-bit mux with capture enable and valid strobe (optional y_par via MUX_4_TO_1_PARITY_EN)
module mux_4_to_1 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic             s0,
    input  logic             s1,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
`ifdef MUX_4_TO_1_PARITY_EN
    output logic             y_par,
`endif
    output logic [1:0]       sel_q
);
    logic [WIDTH-1:0] mux_w;
    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_q;
    logic             y_valid_d;
    logic             y_valid_q;
    logic [1:0]       sel_d;
`ifdef MUX_4_TO_1_PARITY_EN
    logic             y_par_d;
    logic             y_par_q;
`endif

    // full select decode; capture on en, otherwise hold, strobe follows en
    always_comb begin
        mux_w     = s1 ? (s0 ? i3 : i2) : (s0 ? i1 : i0);
        y_d       = en ? mux_w : y_q;
        sel_d     = en ? {s1, s0} : sel_q;
        y_valid_d = en;
`ifdef MUX_4_TO_1_PARITY_EN
        y_par_d   = en ? ^mux_w : y_par_q;
`endif
    end

    // output registers, cleared immediately by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            sel_q     <= 2'b00;
`ifdef MUX_4_TO_1_PARITY_EN
            y_par_q   <= 1'b0;
`endif
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            sel_q     <= sel_d;
`ifdef MUX_4_TO_1_PARITY_EN
            y_par_q   <= y_par_d;
`endif
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
`ifdef MUX_4_TO_1_PARITY_EN
    assign y_par   = y_par_q;
`endif
endmodule

// File: tb/tb_mux_4_to_1.sv
// tb_mux_4_to_1: directed checks of mux_4_to_1 at WIDTH=1 and WIDTH=8
module tb_mux_4_to_1;
    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       s0;
    logic       s1;
    logic       a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    logic       y1;
    logic       v1;
    logic [1:0] q1;
    logic [7:0] y8;
    logic       v8;
    logic [1:0] q8;
    logic       p1;
    logic       p8;
    int         passed = 0;
    int         total  = 0;
    logic [7:0] exp8 [4];

    always #5 clk = ~clk;

    mux_4_to_1 #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .en(en),
        .i0(a0), .i1(a1), .i2(a2), .i3(a3),
        .s0(s0), .s1(s1),
        .y(y1), .y_valid(v1),
`ifdef MUX_4_TO_1_PARITY_EN
        .y_par(p1),
`endif
        .sel_q(q1)
    );

    mux_4_to_1 #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .en(en),
        .i0(b0), .i1(b1), .i2(b2), .i3(b3),
        .s0(s0), .s1(s1),
        .y(y8), .y_valid(v8),
`ifdef MUX_4_TO_1_PARITY_EN
        .y_par(p8),
`endif
        .sel_q(q8)
    );

`ifndef MUX_4_TO_1_PARITY_EN
    assign p1 = 1'b0;
    assign p8 = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, " y1"}, {31'd0, y1}, 32'd0);
        chk({tag, " v1"}, {31'd0, v1}, 32'd0);
        chk({tag, " q1"}, {30'd0, q1}, 32'd0);
        chk({tag, " y8"}, {24'd0, y8}, 32'd0);
        chk({tag, " v8"}, {31'd0, v8}, 32'd0);
        chk({tag, " q8"}, {30'd0, q8}, 32'd0);
`ifdef MUX_4_TO_1_PARITY_EN
        chk({tag, " p8"}, {31'd0, p8}, 32'd0);
`endif
    endtask

    initial begin
        exp8 = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        rst = 1'b1; en = 1'b0; s0 = 1'b0; s1 = 1'b0;
        {a0, a1, a2, a3} = 4'b0;
        {b0, b1, b2, b3} = 32'd0;
        #2;
        for (int i = 0; i < 4; i++) begin
            en = 1'($urandom); s0 = 1'($urandom); s1 = 1'($urandom);
            {a0, a1, a2, a3} = 4'($urandom);
            {b0, b1, b2, b3} = $urandom;
            tick();
            chk_rst("reset_hold");
        end
        rst = 1'b0; en = 1'b0;
        tick();
        tick();
        chk_rst("post_release");

        {a0, a1, a2, a3} = 4'b0101;
        b0 = 8'hA5; b1 = 8'h3C; b2 = 8'hFF; b3 = 8'h00;
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            {s1, s0} = 2'(k);
            tick();
            chk("sweep y1", {31'd0, y1}, {31'd0, k[0]});
            chk("sweep q1", {30'd0, q1}, 32'(k));
            chk("sweep v1", {31'd0, v1}, 32'd1);
            chk("sweep y8", {24'd0, y8}, {24'd0, exp8[k]});
            chk("sweep q8", {30'd0, q8}, 32'(k));
            chk("sweep v8", {31'd0, v8}, 32'd1);
`ifdef MUX_4_TO_1_PARITY_EN
            chk("sweep p8", {31'd0, p8}, 32'd0);
`endif
        end

        b1 = 8'h01; {s1, s0} = 2'b01;
        tick();
        chk("par y8", {24'd0, y8}, 32'h01);
        chk("par y1", {31'd0, y1}, 32'd1);
`ifdef MUX_4_TO_1_PARITY_EN
        chk("par p8", {31'd0, p8}, 32'd1);
        chk("par p1", {31'd0, p1}, 32'd1);
`endif

        en = 1'b0; {s1, s0} = 2'b10; a2 = 1'b0; a1 = 1'b0; b1 = 8'h77;
        tick();
        chk("gate y1", {31'd0, y1}, 32'd1);
        chk("gate v1", {31'd0, v1}, 32'd0);
        chk("gate q1", {30'd0, q1}, 32'd1);
        chk("gate y8", {24'd0, y8}, 32'h01);
        {s1, s0} = 2'b11; b3 = 8'h5A;
        tick();
        chk("gate2 y8", {24'd0, y8}, 32'h01);
        chk("gate2 q8", {30'd0, q8}, 32'd1);
`ifdef MUX_4_TO_1_PARITY_EN
        chk("gate2 p8", {31'd0, p8}, 32'd1);
`endif

        en = 1'b1; {s1, s0} = 2'b10;
        tick();
        chk("pre_async y8", {24'd0, y8}, 32'hFF);
        chk("pre_async v8", {31'd0, v8}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_rst("async");

        tick();
        chk_rst("collision");

        #1 rst = 1'b0; {s1, s0} = 2'b01; b1 = 8'h01;
        tick();
        chk("first y8", {24'd0, y8}, 32'h01);
        chk("first v8", {31'd0, v8}, 32'd1);
        chk("first q8", {30'd0, q8}, 32'd1);
        en = 1'b0;
        tick();
        chk("drop v8", {31'd0, v8}, 32'd0);
        chk("drop y8", {24'd0, y8}, 32'h01);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
